// File: rtl/axis_peak_buffer_if.sv
`default_nettype none
// ============================================================================
// axis_peak_buffer_if : AXI-Stream beat bundle (tdata/tstrb/tvalid/tlast/tready)
// Revision 1.0
// ============================================================================
interface axis_peak_buffer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_peak_buffer.sv
`default_nettype none
// ============================================================================
// axis_peak_buffer : reduces each s01 packet to its peak strobed beat and
// queues results for single-beat m01 output. Optional min mode: AXIS_PEAK_MIN_EN.
// Revision 1.0
// ============================================================================
module axis_peak_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int SIGNED_CMP = 0
) (
  input  logic                         axis_aclk,
  input  logic                         axis_areset,
  axis_peak_buffer_if.slave            s01_axis,
  axis_peak_buffer_if.master           m01_axis,
`ifdef AXIS_PEAK_MIN_EN
  input  logic                         mode_min,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  hit_q, hit_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0]      mem_hit_q;

  logic                  w_full, w_empty, w_in_fire, w_push, w_pop;
  logic                  w_beat_ok, w_gt, w_better, w_take, w_new_hit;
  logic [DATA_WIDTH-1:0] w_new_acc, w_push_data;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign w_empty = (count_q == '0);

  assign s01_axis.tready = ~w_full & ~axis_areset;
  assign w_in_fire       = s01_axis.tvalid & s01_axis.tready;
  assign w_push          = w_in_fire & s01_axis.tlast;
  assign w_pop           = ~w_empty & m01_axis.tready;

  assign w_beat_ok = &s01_axis.tstrb;
  assign w_gt = (SIGNED_CMP != 0) ? ($signed(s01_axis.tdata) > $signed(acc_q))
                                  : (s01_axis.tdata > acc_q);

`ifdef AXIS_PEAK_MIN_EN
  logic mode_q;
  logic w_lt, w_mode;

  assign w_lt = (SIGNED_CMP != 0) ? ($signed(s01_axis.tdata) < $signed(acc_q))
                                  : (s01_axis.tdata < acc_q);
  // Mode is latched on the first beat of a packet; later beats reuse the latched value.
  assign w_mode   = (state_q == S_IDLE) ? mode_min : mode_q;
  assign w_better = w_mode ? w_lt : w_gt;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      mode_q <= 1'b0;
    end else if (w_in_fire && (state_q == S_IDLE)) begin
      mode_q <= mode_min;
    end
  end
`else
  assign w_better = w_gt;
`endif

  assign w_take      = w_beat_ok & (~hit_q | w_better);
  assign w_new_acc   = w_take ? s01_axis.tdata : acc_q;
  assign w_new_hit   = hit_q | w_take;
  assign w_push_data = w_new_hit ? w_new_acc : '0;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    hit_d   = hit_q;
    if (w_in_fire) begin
      if (s01_axis.tlast) begin
        state_d = S_IDLE;
        acc_d   = '0;
        hit_d   = 1'b0;
      end else begin
        state_d = S_ACCUM;
        acc_d   = w_new_acc;
        hit_d   = w_new_hit;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      hit_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hit_q   <= hit_d;
      count_q <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge axis_aclk) begin
    if (w_push) begin
      mem_data_q[wr_ptr_q] <= w_push_data;
      mem_hit_q[wr_ptr_q]  <= w_new_hit;
    end
  end

  assign m01_axis.tvalid = ~w_empty;
  assign m01_axis.tdata  = w_empty ? '0 : mem_data_q[rd_ptr_q];
  assign m01_axis.tstrb  = (~w_empty & mem_hit_q[rd_ptr_q]) ? {STRB_W{1'b1}} : '0;
  assign m01_axis.tlast  = ~w_empty;
  assign fifo_count      = count_q;

endmodule
`default_nettype wire
